xpb_reduce_seq: RTL and testbench
=================================

Name: xpb_reduce_seq

Overview:
Sequential reduction stage that consumes the xpb lookup tables. It takes a squaring result split into a WIDTH-bit lower part and NUM_DIGITS upper digits of DIGIT_BITS each. It walks the upper digits one per cycle, drives each digit into the external xpb table bank, and accumulates the returned WIDTH-bit precomputed multiple onto the lower part. The output is a WIDTH+GUARD-bit partially reduced value, congruent to the full input mod N, for the next squaring iteration.

Parameters:
WIDTH, 1024, width of the lower part and of every xpb table entry
DIGIT_BITS, 5, bits per upper digit (table select width)
NUM_DIGITS, 8, number of upper digits processed per transaction
GUARD, 4, extra accumulator MSBs; must satisfy GUARD >= clog2(NUM_DIGITS+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept a transaction
in_lower  in  WIDTH  lower part of the value to reduce
in_upper  in  NUM_DIGITS*DIGIT_BITS  upper digits; digit i = bits [i*DIGIT_BITS +: DIGIT_BITS]
lut_digit_idx  out  clog2(NUM_DIGITS)  selects which digit-position table in the bank
lut_digit  out  DIGIT_BITS  table index (the digit value)
lut_data  in  WIDTH  table entry; combinational from lut_digit_idx/lut_digit in the same cycle
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH+GUARD  accumulated result

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/reset.
- FSM states are IDLE, ACCUM and DONE.
- Reset state: IDLE. acc=0, idx=0, out_valid=0, out_data=0, lut_digit=0, lut_digit_idx=0. in_ready is forced 0 while reset is high.
- in_ready = (state==IDLE) && !reset. It is combinational from state.
- IDLE: on an in_valid && in_ready edge:
  - acc <= zero-extended in_lower
  - upper register <= in_upper
  - idx <= 0
  - state -> ACCUM
- ACCUM:
  - lut_digit_idx = idx and lut_digit = upper digit[idx], driven from registers.
  - Each edge: acc <= acc + lut_data, a full WIDTH+GUARD binary add.
  - Digit value 0 is still added (the table returns 0). There is no skipping, so the cycle count is fixed.
  - When idx==NUM_DIGITS-1: state -> DONE and out_valid <= 1. Otherwise idx <= idx+1.
- DONE:
  - out_data = acc, held stable.
  - lut_digit and lut_digit_idx are driven 0.
  - On out_valid && out_ready: out_valid <= 0 and state -> IDLE.
- Latency: when the accept edge is E0, out_valid rises after edge E0+NUM_DIGITS.
- Throughput: with out_ready=1, the minimum spacing between accepts is NUM_DIGITS+2 cycles. There is no accept in DONE, even in the same cycle as the output handshake.
- No overflow is possible: the sum is less than (NUM_DIGITS+1)*2^WIDTH, which is at most 2^(WIDTH+GUARD). Wrap-around is therefore a parameter-rule violation, not a runtime case.
- Backpressure: while out_ready=0 in DONE, out_data and out_valid hold and in_valid is ignored.
- Reset mid-ACCUM or mid-DONE: the partial result is discarded and the FSM returns to IDLE. in_ready is 1 on the first cycle after reset deasserts.
- in_lower and in_upper are sampled only at the accept edge. Later changes have no effect.

Decomposition:
- Package xpb_reduce_pkg holds:
  - WIDTH, DIGIT_BITS, NUM_DIGITS and GUARD defaults
  - the derived IDX_BITS = clog2(NUM_DIGITS)
  - the state enum typedef (IDLE, ACCUM, DONE)
- No sub-module is needed: the adder and the digit mux are inline.
- The table bank (xpb_lut_bank, instancing the per-position xpb tables, muxed by lut_digit_idx) is a peer block wired at the parent level, not inside this one.

Test Plan:
1. Bench stub lut_data = digit value, zero-extended. in_lower=0x5, all 8 digits=0x1F -> out_data=0xFD; out_valid 8 cycles after the accept edge; lut_digit_idx steps 0..7.
2. Stub returns 2^1024-1 for any digit; in_lower=2^1024-1, all digits=1 -> out_data=9*(2^1024-1), top 4 bits=0x8, no truncation.
3. Digits {7:0}=0x01..0x08 with stub lut_data = (idx<<8)|digit -> lut_digit matches slice i each cycle; out_data = in_lower + 0x1C24.
4. Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_data constant, in_ready=0, no second accept; accept occurs 2 cycles after out_ready rises.
5. Assert reset for 1 cycle at idx=3 -> out_valid stays 0, in_ready=1 next cycle; the following transaction (test 1 vector) returns 0xFD.
6. in_valid held high and out_ready=1 -> accepts spaced exactly 10 cycles apart; two different vectors give correct independent results.

Source files
------------

// File: rtl/xpb_reduce_pkg.sv
// Shared constants and types for the xpb sequential reduction stage.
package xpb_reduce_pkg;

    // Default geometry: 1024-bit lower part, eight 5-bit upper digits.
    localparam int DEF_WIDTH      = 1024;
    localparam int DEF_DIGIT_BITS = 5;
    localparam int DEF_NUM_DIGITS = 8;
    // Must cover the sum of NUM_DIGITS+1 WIDTH-bit terms: GUARD >= clog2(NUM_DIGITS+1).
    localparam int DEF_GUARD      = 4;

    // Width of the digit-position select into the table bank.
    localparam int IDX_BITS = $clog2(DEF_NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/xpb_reduce_seq.sv
// Sequential xpb reduction: walks the upper digits one per cycle, looks each
// one up in the external xpb table bank and accumulates the returned multiple
// onto the lower part. The result is congruent to the full input mod N.
module xpb_reduce_seq
    import xpb_reduce_pkg::*;
#(
    parameter int  WIDTH      = DEF_WIDTH,
    parameter int  DIGIT_BITS = DEF_DIGIT_BITS,
    parameter int  NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int  GUARD      = DEF_GUARD,
    localparam int IDX_W      = $clog2(NUM_DIGITS),
    localparam int ACC_W      = WIDTH + GUARD,
    localparam int UPPER_W    = NUM_DIGITS * DIGIT_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_lower,
    input  logic [UPPER_W-1:0]    in_upper,
    output logic [IDX_W-1:0]      lut_digit_idx,
    output logic [DIGIT_BITS-1:0] lut_digit,
    input  logic [WIDTH-1:0]      lut_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    out_valid_q, out_valid_d;
    logic [UPPER_W-1:0]      upper_q;
    logic [DIGIT_BITS-1:0]   digits [NUM_DIGITS];
    logic                    accept;

    assign accept = in_valid && in_ready;

    // State and datapath registers; synchronous reset discards any partial result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values,
        // so the order of these statements cannot change behaviour.
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Capture the upper digits at the accept edge only.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose: upper_q is pure data, always loaded at
        // accept before ACCUM reads it, so a reset term would only add muxing.
        if (accept) begin
            upper_q <= in_upper;
        end
    end

    // Next-state and accumulator update.
    always_comb begin
        // NOTE: hold-value defaults first so no path through the case leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(in_lower);
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Digit 0 still adds (the table returns 0) so latency is fixed.
                acc_d = acc_q + ACC_W'(lut_data);
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // No accept here even on the handshake cycle; IDLE follows first.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unpack the registered upper field into addressable digits.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = upper_q[i*DIGIT_BITS +: DIGIT_BITS];
        end
    end

    // Outputs: table address only while accumulating, result straight from acc.
    always_comb begin
        in_ready      = (state_q == IDLE) && !reset;
        lut_digit_idx = '0;
        lut_digit     = '0;
        if (state_q == ACCUM) begin
            lut_digit_idx = idx_q;
            lut_digit     = digits[idx_q];
        end
        out_valid = out_valid_q;
        out_data  = acc_q;
    end

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Self-checking bench for xpb_reduce_seq with a behavioural table stub and a
// sum-of-lookups reference model.
module tb_xpb_reduce_seq;
    import xpb_reduce_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int DB = DEF_DIGIT_BITS;
    localparam int ND = DEF_NUM_DIGITS;
    localparam int G  = DEF_GUARD;
    localparam int IB = IDX_BITS;
    localparam int OW = W + G;
    localparam int UW = ND * DB;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_lower;
    logic [UW-1:0] in_upper;
    logic [IB-1:0] lut_digit_idx;
    logic [DB-1:0] lut_digit;
    logic [W-1:0]  lut_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int lut_mode = 0;
    logic [W-1:0] lut_tbl [ND][2**DB];
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc [$];

    xpb_reduce_seq dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lower     (in_lower),
        .in_upper     (in_upper),
        .lut_digit_idx(lut_digit_idx),
        .lut_digit    (lut_digit),
        .lut_data     (lut_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    // Table stub: 0 = digit value, 1 = all ones, 2 = (pos<<8)|digit, 3 = random table.
    function automatic logic [W-1:0] lut_val(input int mode, input int pos, input int dig);
        logic [W-1:0] v;
        case (mode)
            0:       v = W'(dig);
            1:       v = '1;
            2:       v = W'((pos << 8) | dig);
            default: v = lut_tbl[pos][dig];
        endcase
        return v;
    endfunction

    assign lut_data = lut_val(lut_mode, int'(lut_digit_idx), int'(lut_digit));

    // Reference: lower part plus the table entry selected by every digit.
    function automatic logic [OW-1:0] model(input logic [W-1:0] lower, input logic [UW-1:0] upper,
                                            input int mode);
        logic [OW-1:0] s;
        s = OW'(lower);
        for (int i = 0; i < ND; i++) begin
            s = s + OW'(lut_val(mode, i, int'(upper[i*DB +: DB])));
        end
        return s;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [UW-1:0] rand_u();
        logic [UW-1:0] v;
        for (int j = 0; j < ND; j++) v[j*DB +: DB] = DB'($urandom_range(0, 2**DB - 1));
        return v;
    endfunction

    // Accept monitor: records the edge index of every handshake.
    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
        cyc++;
    end

    // Offer one transaction, optionally check the per-cycle table address, and
    // return the result once out_valid rises plus the cycles since the accept edge.
    task automatic do_txn(input logic [W-1:0] lower, input logic [UW-1:0] upper, input bit chk_steps,
                          output logic [OW-1:0] res, output int lat);
        int n;
        @(negedge clk);
        in_lower = lower;
        in_upper = upper;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_lower = rand_w();
        in_upper = rand_u();
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (chk_steps && lat < ND) begin
                checks++;
                if (lut_digit_idx !== IB'(lat) || lut_digit !== upper[lat*DB +: DB]) begin
                    errors++;
                    $display("FAIL lut_step%0d: idx=%0d digit=%h required idx=%0d digit=%h",
                             lat, lut_digit_idx, lut_digit, lat, upper[lat*DB +: DB]);
                end
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== ND) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d", lat, ND);
        end
        checks++;
        if (lut_digit !== '0 || lut_digit_idx !== '0) begin
            errors++;
            $display("FAIL done_lut_zero: idx=%0d digit=%h required 0 0", lut_digit_idx, lut_digit);
        end
        res = out_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== '0 || lut_digit !== '0 || lut_digit_idx !== '0) begin
            errors++;
            $display("FAIL reset_data: out_lo=%h digit=%h idx=%0d required 0 0 0",
                     out_data[63:0], lut_digit, lut_digit_idx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_small_digits();
        logic [OW-1:0] res;
        int lat;
        lut_mode = 0;
        out_ready = 1'b1;
        do_txn(W'(5), {ND{5'h1F}}, 1'b1, res, lat);
        checks++;
        if (res !== OW'(12'hFD)) begin
            errors++;
            $display("FAIL small_digits: got %h required fd", res[63:0]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_handshake: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_max();
        logic [OW-1:0] res;
        logic [OW-1:0] exp_v;
        int lat;
        lut_mode = 1;
        out_ready = 1'b1;
        exp_v = OW'(9) * {{G{1'b0}}, {W{1'b1}}};
        do_txn('1, {ND{5'd1}}, 1'b0, res, lat);
        checks++;
        if (res !== exp_v || res[OW-1 -: G] !== 4'h8) begin
            errors++;
            $display("FAIL max_sum: got %h..%h required %h..%h",
                     res[OW-1 -: 32], res[63:0], exp_v[OW-1 -: 32], exp_v[63:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_digit_mux();
        logic [OW-1:0] res;
        logic [OW-1:0] exp_v;
        logic [W-1:0]  lower;
        logic [UW-1:0] upper;
        int lat;
        lut_mode = 2;
        out_ready = 1'b1;
        for (int i = 0; i < ND; i++) upper[i*DB +: DB] = DB'(i + 1);
        lower = rand_w();
        exp_v = OW'(lower) + OW'(16'h1C24);
        do_txn(lower, upper, 1'b1, res, lat);
        checks++;
        if (res !== exp_v) begin
            errors++;
            $display("FAIL digit_mux: got %h required %h", res[63:0], exp_v[63:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] res;
        logic [W-1:0]  la, lb;
        logic [UW-1:0] ua, ub;
        int lat, base, r, n;
        bit held_ok;
        lut_mode = 3;
        out_ready = 1'b0;
        la = rand_w(); ua = rand_u();
        lb = rand_w(); ub = rand_u();
        do_txn(la, ua, 1'b0, res, lat);
        checks++;
        if (res !== model(la, ua, 3)) begin
            errors++;
            $display("FAIL bp_result: got %h required %h", res[63:0], model(la, ua, 3) >> 0);
        end
        in_lower = lb;
        in_upper = ub;
        in_valid = 1'b1;
        base = acc_cnt;
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_data !== res || out_valid !== 1'b1 || in_ready !== 1'b0) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok || acc_cnt !== base) begin
            errors++;
            $display("FAIL bp_hold: held=%0b accepts=%0d required 1 %0d", held_ok, acc_cnt, base);
        end
        out_ready = 1'b1;
        r = cyc;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (acc_cnt !== base + 1 || acc_cyc[acc_cyc.size()-1] !== r + 1) begin
            errors++;
            $display("FAIL bp_accept_time: accepts=%0d edge=%0d required %0d %0d",
                     acc_cnt, acc_cyc[acc_cyc.size()-1], base + 1, r + 1);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== model(lb, ub, 3)) begin
            errors++;
            $display("FAIL bp_second: valid=%0b got %h required %h", out_valid, out_data[63:0],
                     model(lb, ub, 3) >> 0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] res;
        int lat, n;
        bit quiet;
        lut_mode = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_lower = W'(5);
        in_upper = {ND{5'h1F}};
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (lut_digit_idx !== IB'(3)) begin
            errors++;
            $display("FAIL mid_idx: idx=%0d required 3", lut_digit_idx);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
        end
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_discard: out_valid rose after reset, required 0");
        end
        do_txn(W'(5), {ND{5'h1F}}, 1'b0, res, lat);
        checks++;
        if (res !== OW'(12'hFD)) begin
            errors++;
            $display("FAIL mid_followup: got %h required fd", res[63:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  la, lb;
        logic [UW-1:0] ua, ub;
        logic [OW-1:0] results [$];
        int base, n, spacing;
        bit switched;
        lut_mode = 3;
        out_ready = 1'b1;
        la = rand_w(); ua = rand_u();
        lb = rand_w(); ub = rand_u();
        @(negedge clk);
        in_lower = la;
        in_upper = ua;
        in_valid = 1'b1;
        base = acc_cnt;
        switched = 1'b0;
        n = 0;
        while (results.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
            if (acc_cnt == base + 1 && !switched) begin
                in_lower = lb;
                in_upper = ub;
                switched = 1'b1;
            end
            if (acc_cnt >= base + 2) in_valid = 1'b0;
            if (out_valid) results.push_back(out_data);
        end
        in_valid = 1'b0;
        spacing = (acc_cyc.size() >= base + 2) ? acc_cyc[base+1] - acc_cyc[base] : -1;
        checks++;
        if (spacing !== ND + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", spacing, ND + 2);
        end
        checks++;
        if (results.size() != 2 || results[0] !== model(la, ua, 3) || results[1] !== model(lb, ub, 3)) begin
            errors++;
            $display("FAIL b2b_results: count=%0d required 2 with A=%h B=%h", results.size(),
                     model(la, ua, 3) >> 0, model(lb, ub, 3) >> 0);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [OW-1:0] res;
        logic [W-1:0]  lower;
        logic [UW-1:0] upper;
        int lat, hold;
        bit stable;
        lut_mode = 3;
        for (int t = 0; t < 6; t++) begin
            out_ready = 1'b0;
            lower = rand_w();
            upper = rand_u();
            do_txn(lower, upper, 1'b1, res, lat);
            checks++;
            if (res !== model(lower, upper, 3)) begin
                errors++;
                $display("FAIL rand%0d_result: got %h required %h", t, res[63:0],
                         model(lower, upper, 3) >> 0);
            end
            hold = $urandom_range(0, 3);
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (out_data !== res || out_valid !== 1'b1) stable = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (!stable || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_hold: stable=%0b out_valid=%0b required 1 0", t, stable, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < ND; p++) begin
            for (int d = 0; d < 2**DB; d++) begin
                lut_tbl[p][d] = (d == 0) ? '0 : rand_w();
            end
        end
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_lower = '0;
        in_upper = '0;
        test_reset();
        test_small_digits();
        test_max();
        test_digit_mux();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
